// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array GEMM sequencer.
// - Default geometry of the array and its SRAM banks.
// - Ctrl-state encodings driven onto systolic_array_top's i_ctrl_state.
// - Sequencer FSM state encoding.
package sa_pkg;

  localparam int DEF_NUM_ROW              = 4;
  localparam int DEF_NUM_COL              = 4;
  localparam int DEF_ACCU_DATA_WIDTH      = 32;
  localparam int DEF_LOG2_SRAM_BANK_DEPTH = 5;
  localparam int DEF_CTRL_WIDTH           = 4;

  // SRAM address width follows the bank depth.
  localparam int DEF_AW = DEF_LOG2_SRAM_BANK_DEPTH;

  // Array ctrl-state encodings; must match systolic_array_top.
  localparam logic [3:0] CTRL_IDLE   = 4'd0;
  localparam logic [3:0] CTRL_WARMUP = 4'd1;
  localparam logic [3:0] CTRL_STEADY = 4'd2;
  localparam logic [3:0] CTRL_DRAIN  = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_STEADY,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

endpackage

// File: rtl/sa_phase_counter.sv
// Phase-length counter.
// - load : restart at 0 and capture a new length (asserted on state entry)
// - len  : length in cycles, sampled when load is high
// - count: cycles elapsed since the last load
// - last : high in the final cycle of the phase (count == len-1)
module sa_phase_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] len_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      len_q <= '0;
    end else if (load) begin
      count <= '0;
      len_q <= len;
    end else begin
      count <= count + W'(1);
    end
  end

  assign last = (count == len_q - W'(1));

endmodule

// File: rtl/sa_gemm_sequencer.sv
// Run-time controller for systolic_array_top: sequences one output-stationary
// tile op (WARMUP -> STEADY -> DRAIN -> readout of the down SRAM).
// Ports:
// - clk, rst                     clock, synchronous active-high reset
// - i_start                      1-cycle op request, honoured only when idle
// - i_top_start/end              top SRAM read window (inclusive)
// - i_left_start/end             left SRAM read window (inclusive)
// - i_down_start                 down SRAM readout base address
// - o_busy / o_done / o_err      status: op in flight / op finished / bad start
// - o_ctrl_state                 array ctrl state (IDLE/WARMUP/STEADY/DRAIN)
// - o_top_rd_*, o_left_rd_*      latched read windows for the array
// - o_down_rd_en/addr            down SRAM read port
// - i_down_rd_data               down SRAM read data (for the address presented)
// - o_res_valid/data/row         registered result beats, one per array row
module sa_gemm_sequencer
  import sa_pkg::*;
#(
  parameter int NUM_ROW              = DEF_NUM_ROW,
  parameter int NUM_COL              = DEF_NUM_COL,
  parameter int ACCU_DATA_WIDTH      = DEF_ACCU_DATA_WIDTH,
  parameter int LOG2_SRAM_BANK_DEPTH = DEF_LOG2_SRAM_BANK_DEPTH,
  parameter int CTRL_WIDTH           = DEF_CTRL_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_top_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_top_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_left_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_left_end,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_down_start,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [CTRL_WIDTH-1:0]              o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_top_rd_start,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_top_rd_end,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_left_rd_start,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_left_rd_end,
  output logic                               o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_down_rd_addr,
  input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0] i_down_rd_data,
  output logic                               o_res_valid,
  output logic [NUM_COL*ACCU_DATA_WIDTH-1:0] o_res_data,
  output logic [$clog2(NUM_ROW)-1:0]         o_res_row
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int CW = AW + 1;  // holds a full-bank window length without wrap
  localparam int RW = $clog2(NUM_ROW);

  localparam logic [CW-1:0] DRAIN_LEN = CW'(NUM_ROW + NUM_COL - 1);
  // One extra cycle lets the final read beat land before S_DONE.
  localparam logic [CW-1:0] READ_LEN  = CW'(NUM_ROW + 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(NUM_ROW - 1);

  state_t        state;
  logic [AW-1:0] down_q;

  logic          win_ok;
  logic [CW-1:0] k_top_in;
  logic [CW-1:0] k_left;

  logic          phase_load;
  logic [CW-1:0] phase_len;
  logic [CW-1:0] phase_cnt;
  logic          phase_last;

  logic          read_load;
  logic [CW-1:0] read_cnt;
  logic          read_last;

  // Window lengths are computed one bit wider so a full-bank window is legal.
  assign win_ok   = (i_top_end >= i_top_start) && (i_left_end >= i_left_start);
  assign k_top_in = {1'b0, i_top_end} - {1'b0, i_top_start} + CW'(1);
  assign k_left   = {1'b0, o_left_rd_end} - {1'b0, o_left_rd_start} + CW'(1);

  // The phase counter reloads on the same edge the FSM enters the next phase,
  // so the length offered here belongs to the phase being entered.
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    phase_load = 1'b0;
    phase_len  = '0;
    unique case (state)
      S_IDLE: begin
        phase_load = i_start && win_ok;
        phase_len  = k_top_in;
      end
      S_WARMUP: begin
        phase_load = phase_last;
        phase_len  = k_left;
      end
      S_STEADY: begin
        phase_load = phase_last;
        phase_len  = DRAIN_LEN;
      end
      default: ;
    endcase
  end

  assign read_load = (state == S_DRAIN) && phase_last;

  sa_phase_counter #(.W(CW)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (phase_load),
    .len   (phase_len),
    .count (phase_cnt),
    .last  (phase_last)
  );

  sa_phase_counter #(.W(CW)) u_read_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (read_load),
    .len   (READ_LEN),
    .count (read_cnt),
    .last  (read_last)
  );

  // Only completion is signalled through phase_last; the raw phase count is
  // not needed by the FSM.
  logic unused_phase_cnt;
  assign unused_phase_cnt = ^phase_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      down_q          <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
      o_ctrl_state    <= CTRL_WIDTH'(CTRL_IDLE);
      o_top_rd_start  <= '0;
      o_top_rd_end    <= '0;
      o_left_rd_start <= '0;
      o_left_rd_end   <= '0;
      o_down_rd_en    <= 1'b0;
      o_down_rd_addr  <= '0;
      o_res_valid     <= 1'b0;
      o_res_data      <= '0;
      o_res_row       <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;

      // Down SRAM data is captured in the cycle its address is presented, so
      // the result beat trails the read enable by exactly one cycle.
      o_res_valid <= o_down_rd_en;
      if (o_down_rd_en) begin
        o_res_data <= i_down_rd_data;
        o_res_row  <= read_cnt[RW-1:0];
      end

      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            if (win_ok) begin
              state           <= S_WARMUP;
              o_busy          <= 1'b1;
              o_ctrl_state    <= CTRL_WIDTH'(CTRL_WARMUP);
              o_top_rd_start  <= i_top_start;
              o_top_rd_end    <= i_top_end;
              o_left_rd_start <= i_left_start;
              o_left_rd_end   <= i_left_end;
              down_q          <= i_down_start;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_WARMUP: begin
          if (phase_last) begin
            state        <= S_STEADY;
            o_ctrl_state <= CTRL_WIDTH'(CTRL_STEADY);
          end
        end
        S_STEADY: begin
          if (phase_last) begin
            state        <= S_DRAIN;
            o_ctrl_state <= CTRL_WIDTH'(CTRL_DRAIN);
          end
        end
        S_DRAIN: begin
          if (phase_last) begin
            state          <= S_READ;
            o_ctrl_state   <= CTRL_WIDTH'(CTRL_IDLE);
            o_down_rd_en   <= 1'b1;
            o_down_rd_addr <= down_q;
          end
        end
        S_READ: begin
          // read_cnt is the row being read this cycle; set up the next one.
          if (read_cnt < LAST_ROW) begin
            o_down_rd_addr <= down_q + read_cnt[AW-1:0] + AW'(1);
          end else begin
            o_down_rd_en   <= 1'b0;
            o_down_rd_addr <= '0;
          end
          if (read_last) begin
            state  <= S_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_gemm_sequencer.sv
// Self-checking bench for sa_gemm_sequencer. A behavioural down SRAM answers
// reads combinationally; expected traces are derived from window lengths.
module tb_sa_gemm_sequencer;

  localparam int NUM_ROW = 4;
  localparam int NUM_COL = 4;
  localparam int ADW     = 32;
  localparam int AW      = 5;
  localparam int CTW     = 4;
  localparam int DW      = NUM_COL * ADW;
  localparam int DEPTH   = 1 << AW;
  localparam int DRAIN   = NUM_ROW + NUM_COL - 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_start;
  logic [AW-1:0]              i_top_start, i_top_end;
  logic [AW-1:0]              i_left_start, i_left_end;
  logic [AW-1:0]              i_down_start;
  logic                       o_busy, o_done, o_err;
  logic [CTW-1:0]             o_ctrl_state;
  logic [AW-1:0]              o_top_rd_start, o_top_rd_end;
  logic [AW-1:0]              o_left_rd_start, o_left_rd_end;
  logic                       o_down_rd_en;
  logic [AW-1:0]              o_down_rd_addr;
  logic [DW-1:0]              i_down_rd_data;
  logic                       o_res_valid;
  logic [DW-1:0]              o_res_data;
  logic [$clog2(NUM_ROW)-1:0] o_res_row;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign i_down_rd_data = mem[o_down_rd_addr];

  sa_gemm_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_top_start     (i_top_start),
    .i_top_end       (i_top_end),
    .i_left_start    (i_left_start),
    .i_left_end      (i_left_end),
    .i_down_start    (i_down_start),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_ctrl_state    (o_ctrl_state),
    .o_top_rd_start  (o_top_rd_start),
    .o_top_rd_end    (o_top_rd_end),
    .o_left_rd_start (o_left_rd_start),
    .o_left_rd_end   (o_left_rd_end),
    .o_down_rd_en    (o_down_rd_en),
    .o_down_rd_addr  (o_down_rd_addr),
    .i_down_rd_data  (i_down_rd_data),
    .o_res_valid     (o_res_valid),
    .o_res_data      (o_res_data),
    .o_res_row       (o_res_row)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_output();
    return |{o_busy, o_done, o_err, o_ctrl_state, o_top_rd_start, o_top_rd_end,
             o_left_rd_start, o_left_rd_end, o_down_rd_en, o_down_rd_addr,
             o_res_valid, o_res_data, o_res_row};
  endfunction

  // Runs one tile op and compares the observed trace with what the window
  // lengths imply: phase run-lengths, latency, read addresses and beats.
  task automatic run_op(input string name, input int ts, input int te, input int ls,
                        input int le, input int ds, input bit inject);
    int kt, kl, exp_done;
    int c1, c2, c3, first3, busy_cnt, done_cnt, done_at, err_cnt, first_rd, first_res;
    int addr_q[$];
    int row_q[$];
    logic [DW-1:0] res_q[$];
    bit injected;
    kt = te - ts + 1;
    kl = le - ls + 1;
    exp_done = 1 + kt + kl + DRAIN + NUM_ROW + 1;
    c1 = 0; c2 = 0; c3 = 0; first3 = -1; busy_cnt = 0; done_cnt = 0; done_at = -1;
    err_cnt = 0; first_rd = -1; first_res = -1; injected = 1'b0;

    i_top_start  = AW'(ts);
    i_top_end    = AW'(te);
    i_left_start = AW'(ls);
    i_left_end   = AW'(le);
    i_down_start = AW'(ds);
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    check({name, ":latched_windows"},
          DW'({o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end}),
          DW'({AW'(ts), AW'(te), AW'(ls), AW'(le)}));

    for (int n = 1; n <= exp_done + 40; n++) begin
      if (n > 1) tick();
      i_start = 1'b0;
      case (o_ctrl_state)
        CTW'(1): c1++;
        CTW'(2): c2++;
        CTW'(3): begin
          c3++;
          if (first3 < 0) first3 = n;
        end
        default: ;
      endcase
      if (o_busy) busy_cnt++;
      if (o_err) err_cnt++;
      if (o_down_rd_en) begin
        addr_q.push_back(int'(o_down_rd_addr));
        if (first_rd < 0) first_rd = n;
      end
      if (o_res_valid) begin
        res_q.push_back(o_res_data);
        row_q.push_back(int'(o_res_row));
        if (first_res < 0) first_res = n;
      end
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (inject && !injected && o_ctrl_state == CTW'(2)) begin
        // A second request mid-op with different windows must be ignored.
        injected     = 1'b1;
        i_start      = 1'b1;
        i_top_start  = AW'(ts + 3);
        i_top_end    = AW'(31);
        i_left_start = AW'(ls + 5);
        i_left_end   = AW'(31);
        i_down_start = AW'(ds + 9);
      end
      if (done_at > 0 && n >= done_at + 3) break;
    end

    check({name, ":done_count"}, DW'(done_cnt), DW'(1));
    check({name, ":start_to_done"}, DW'(done_at), DW'(exp_done));
    check({name, ":warmup_cycles"}, DW'(c1), DW'(kt));
    check({name, ":steady_cycles"}, DW'(c2), DW'(kl));
    check({name, ":drain_cycles"}, DW'(c3), DW'(DRAIN));
    check({name, ":drain_entry"}, DW'(first3), DW'(1 + kt + kl));
    check({name, ":busy_cycles"}, DW'(busy_cnt), DW'(exp_done - 1));
    check({name, ":no_err"}, DW'(err_cnt), DW'(0));
    check({name, ":rd_count"}, DW'(addr_q.size()), DW'(NUM_ROW));
    check({name, ":beat_count"}, DW'(res_q.size()), DW'(NUM_ROW));
    check({name, ":beat_latency"}, DW'(first_res - first_rd), DW'(1));
    for (int r = 0; r < NUM_ROW; r++) begin
      if (r < addr_q.size())
        check($sformatf("%s:rd_addr%0d", name, r), DW'(addr_q[r]), DW'((ds + r) % DEPTH));
      if (r < res_q.size()) begin
        check($sformatf("%s:beat_row%0d", name, r), DW'(row_q[r]), DW'(r));
        check($sformatf("%s:beat_data%0d", name, r), res_q[r], mem[(ds + r) % DEPTH]);
      end
    end
    check({name, ":windows_held"},
          DW'({o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end}),
          DW'({AW'(ts), AW'(te), AW'(ls), AW'(le)}));
  endtask

  initial begin
    int a [NUM_ROW][NUM_ROW];
    int b [NUM_ROW][NUM_COL];
    int ts, te, ls, le, kt, kl, cnt;
    logic [DW-1:0] row;
    bit reached;

    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};

    rst = 1'b1; i_start = 1'b0;
    i_top_start = '0; i_top_end = '0; i_left_start = '0; i_left_end = '0; i_down_start = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset then idle: everything quiet.
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_outputs_c%0d", i), DW'(any_output()), DW'(0));
    end

    // Golden tile: down SRAM rows 0..3 hold C = A*B.
    for (int i = 0; i < NUM_ROW; i++)
      for (int k = 0; k < NUM_ROW; k++) begin
        a[i][k] = int'($urandom_range(0, 255));
        b[i][k] = int'($urandom_range(0, 255));
      end
    for (int i = 0; i < NUM_ROW; i++) begin
      row = '0;
      for (int j = 0; j < NUM_COL; j++) begin
        cnt = 0;
        for (int k = 0; k < NUM_ROW; k++) cnt += a[i][k] * b[k][j];
        row[j*ADW +: ADW] = ADW'(cnt);
      end
      mem[i] = row;
    end
    run_op("golden", 0, 3, 0, 3, 0, 1'b0);

    // Bad top window: error pulse, nothing starts, windows kept.
    i_top_start = AW'(5); i_top_end = AW'(2); i_left_start = '0; i_left_end = AW'(3);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("bad_top:err", DW'(o_err), DW'(1));
    check("bad_top:busy_ctrl", DW'({o_busy, o_ctrl_state}), DW'(0));
    check("bad_top:windows_kept", DW'({o_top_rd_start, o_top_rd_end}), DW'({AW'(0), AW'(3)}));
    tick();
    check("bad_top:err_one_cycle", DW'({o_err, o_busy, o_ctrl_state}), DW'(0));

    // Bad left window.
    i_top_start = AW'(1); i_top_end = AW'(1); i_left_start = AW'(9); i_left_end = AW'(8);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("bad_left:err", DW'({o_err, o_busy}), DW'(2'b10));
    tick();

    // Down-address wrap and mid-op start.
    run_op("wrap", 2, 4, 7, 8, 30, 1'b0);
    run_op("inject", 2, 7, 10, 12, 5, 1'b1);

    // Boundary windows: full bank and single entry.
    run_op("full_bank", 0, 31, 31, 31, 28, 1'b0);

    // Random windows.
    for (int t = 0; t < 5; t++) begin
      kt = int'($urandom_range(1, 8));
      kl = int'($urandom_range(1, 8));
      ts = int'($urandom_range(0, DEPTH - kt));
      ls = int'($urandom_range(0, DEPTH - kl));
      te = ts + kt - 1;
      le = ls + kl - 1;
      run_op($sformatf("rand%0d", t), ts, te, ls, le, int'($urandom_range(0, DEPTH - 1)), t[0]);
    end

    // Reset during DRAIN aborts without a done pulse.
    i_top_start = '0; i_top_end = AW'(3); i_left_start = '0; i_left_end = AW'(3);
    i_down_start = AW'(12);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (o_ctrl_state == CTW'(3)) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("abort:reached_drain", DW'(reached), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort:outputs_cleared", DW'(any_output()), DW'(0));
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (o_done || o_busy || o_down_rd_en) cnt++;
    end
    check("abort:stays_idle", DW'(cnt), DW'(0));
    run_op("after_abort", 4, 6, 20, 23, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
